// File: rtl/arbiter_1_to_n_response_engine_if.sv
// Response fan-out bus: one ingress packet stream in, N engine egress streams out.
interface arbiter_1_to_n_response_engine_if #(
  parameter int NUM_ENGINE_RECEIVER = 2,
  parameter int PAYLOAD_WIDTH       = 64
);
  logic                                         response_in_valid;
  logic [PAYLOAD_WIDTH-1:0]                     response_in_payload;
  logic                                         fifo_response_prog_full_out;
  logic [NUM_ENGINE_RECEIVER-1:0]               fifo_response_rd_en_in;
  logic [NUM_ENGINE_RECEIVER-1:0]               response_out_valid;
  logic [NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH-1:0] response_out_payload;
  logic                                         fifo_setup_signal;
  logic [15:0]                                  drop_count_out;

  modport master (
    output response_in_valid, response_in_payload, fifo_response_rd_en_in,
    input  fifo_response_prog_full_out, response_out_valid, response_out_payload,
           fifo_setup_signal, drop_count_out
  );

  modport slave (
    input  response_in_valid, response_in_payload, fifo_response_rd_en_in,
    output fifo_response_prog_full_out, response_out_valid, response_out_payload,
           fifo_setup_signal, drop_count_out
  );
endinterface

// File: rtl/arbiter_1_to_n_response_engine.sv
// Routes response packets to per-engine egress FIFOs by payload destination index.
// Optional macro ARBITER_1_TO_N_DROP_COUNT_EN builds the out-of-range drop counter.
module arbiter_1_to_n_response_engine_fifo #(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 16,
  parameter int PROG_THRESH = 12
) (
  input  logic             ap_clk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             prog_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, count;
  logic             full, rd_ok, wr_ok;

  assign count     = wptr - rptr;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign prog_full = (count >= (AW+1)'(PROG_THRESH));
  assign rd_ok     = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push then.
  assign wr_ok     = wr_en & (~full | rd_ok);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + (AW+1)'(1);
      if (rd_ok) rptr <= rptr + (AW+1)'(1);
      rd_valid <= rd_ok;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= wr_data;
    if (rd_ok) rd_data <= mem[rptr[AW-1:0]];
  end
endmodule

module arbiter_1_to_n_response_engine #(
  parameter int NUM_ENGINE_RECEIVER = 2,
  parameter int PAYLOAD_WIDTH       = 64,
  parameter int ID_LSB              = 0,
  parameter int ID_WIDTH            = 4,
  parameter int FIFO_INGRESS_DEPTH  = 32,
  parameter int FIFO_EGRESS_DEPTH   = 16,
  parameter int PROG_THRESH         = 12
) (
  input logic                            ap_clk,
  input logic                            areset,
  arbiter_1_to_n_response_engine_if.slave bus
);
  localparam int N  = NUM_ENGINE_RECEIVER;
  localparam int PW = PAYLOAD_WIDTH;
  localparam logic [ID_WIDTH:0] N_EXT = (ID_WIDTH+1)'(NUM_ENGINE_RECEIVER);

  typedef enum logic [1:0] {IDLE, FETCH, ROUTE} state_t;
  state_t state, state_next;

  logic                   in_valid_q;
  logic [PW-1:0]          in_payload_q;
  logic                   ing_rd_en, ing_empty, ing_prog_full, ing_rd_valid;
  logic [PW-1:0]          ing_rd_data;
  logic                   prog_full_q;
  logic [PW-1:0]          hold;
  logic [ID_WIDTH-1:0]    dest;
  logic                   dest_bad, route_done;
  logic [2**ID_WIDTH-1:0] egr_pfull_pad;
  logic [N-1:0]           egr_wr, egr_rd_en, egr_empty, egr_pfull, egr_rd_valid;
  logic [PW-1:0]          egr_rd_data [N];
  logic [N-1:0]           out_valid_q;
  logic [N*PW-1:0]        out_payload_q;
  logic [2:0]             setup_cnt;
  logic                   setup;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      in_valid_q   <= 1'b0;
      in_payload_q <= '0;
      prog_full_q  <= 1'b0;
      setup_cnt    <= '0;
    end else begin
      in_valid_q   <= bus.response_in_valid;
      in_payload_q <= bus.response_in_payload;
      prog_full_q  <= ing_prog_full;
      if (setup_cnt != 3'd4) setup_cnt <= setup_cnt + 3'd1;
    end
  end

  assign setup = (setup_cnt != 3'd4);

  arbiter_1_to_n_response_engine_fifo #(
    .WIDTH(PW), .DEPTH(FIFO_INGRESS_DEPTH), .PROG_THRESH(PROG_THRESH)
  ) u_ingress (
    .ap_clk(ap_clk), .areset(areset),
    .wr_en(in_valid_q), .wr_data(in_payload_q),
    .rd_en(ing_rd_en), .rd_data(ing_rd_data), .rd_valid(ing_rd_valid),
    .empty(ing_empty), .prog_full(ing_prog_full)
  );

  assign dest     = hold[ID_LSB +: ID_WIDTH];
  assign dest_bad = ({1'b0, dest} >= N_EXT);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && ing_rd_valid) hold <= ing_rd_data;
    end
  end

  always_comb begin
    state_next    = state;
    ing_rd_en     = 1'b0;
    egr_wr        = '0;
    route_done    = 1'b0;
    egr_pfull_pad = '0;
    egr_pfull_pad[N-1:0] = egr_pfull;
    case (state)
      IDLE: begin
        if (!ing_empty && !setup) begin
          ing_rd_en  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = ROUTE;
      ROUTE: begin
        // Out-of-range packets complete without a write; in-range ones wait for room.
        if (dest_bad) begin
          route_done = 1'b1;
        end else if (!egr_pfull_pad[dest]) begin
          for (int unsigned i = 0; i < N; i++)
            if (dest == ID_WIDTH'(i)) egr_wr[i] = 1'b1;
          route_done = 1'b1;
        end
        if (route_done) begin
          if (!ing_empty && !setup) begin
            ing_rd_en  = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar g = 0; g < N; g++) begin : g_egress
    assign egr_rd_en[g] = bus.fifo_response_rd_en_in[g] & ~egr_empty[g];

    arbiter_1_to_n_response_engine_fifo #(
      .WIDTH(PW), .DEPTH(FIFO_EGRESS_DEPTH), .PROG_THRESH(PROG_THRESH)
    ) u_egress (
      .ap_clk(ap_clk), .areset(areset),
      .wr_en(egr_wr[g]), .wr_data(hold),
      .rd_en(egr_rd_en[g]), .rd_data(egr_rd_data[g]), .rd_valid(egr_rd_valid[g]),
      .empty(egr_empty[g]), .prog_full(egr_pfull[g])
    );
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      out_valid_q   <= '0;
      out_payload_q <= '0;
    end else begin
      out_valid_q <= egr_rd_valid;
      for (int unsigned i = 0; i < N; i++)
        out_payload_q[i*PW +: PW] <= egr_rd_data[i];
    end
  end

`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
  logic [15:0] drop_cnt;
  always_ff @(posedge ap_clk) begin
    if (areset) drop_cnt <= '0;
    else if (state == ROUTE && dest_bad && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end
  assign bus.drop_count_out = drop_cnt;
`else
  assign bus.drop_count_out = '0;
`endif

  assign bus.response_out_valid          = out_valid_q;
  assign bus.response_out_payload        = out_payload_q;
  assign bus.fifo_response_prog_full_out = prog_full_q;
  assign bus.fifo_setup_signal           = setup;
endmodule

// File: tb/tb_arbiter_1_to_n_response_engine.sv
// Scoreboard bench: stimulus pushes expected packets per engine, a negedge monitor pops and compares.
module tb_arbiter_1_to_n_response_engine;
  localparam int N  = 2;
  localparam int PW = 64;

  logic ap_clk = 1'b0;
  logic areset;
  always #5 ap_clk = ~ap_clk;

  arbiter_1_to_n_response_engine_if #(.NUM_ENGINE_RECEIVER(N), .PAYLOAD_WIDTH(PW)) bus ();

  arbiter_1_to_n_response_engine #(
    .NUM_ENGINE_RECEIVER(N), .PAYLOAD_WIDTH(PW), .ID_LSB(0), .ID_WIDTH(4),
    .FIFO_INGRESS_DEPTH(32), .FIFO_EGRESS_DEPTH(16), .PROG_THRESH(12)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int seen_valid  = 0;
  int exp_drops   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] exp_drop_value();
`ifdef ARBITER_1_TO_N_DROP_COUNT_EN
    return 64'(exp_drops);
`else
    return 64'd0;
`endif
  endfunction

  always @(negedge ap_clk) begin : monitor
    logic [63:0] act, exp;
    if (!areset) begin
      for (int i = 0; i < N; i++) begin
        if (bus.response_out_valid[i]) begin
          seen_valid++;
          act = bus.response_out_payload[i*PW +: PW];
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out%0d: got %h expected no packet", i, act);
          end else begin
            if (i == 0) exp = q0.pop_front();
            else        exp = q1.pop_front();
            check($sformatf("out%0d_payload", i), act, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [63:0] p);
    bus.response_in_valid   = 1'b1;
    bus.response_in_payload = p;
    if (p[3:0] == 4'd0)      q0.push_back(p);
    else if (p[3:0] == 4'd1) q1.push_back(p);
    else                     exp_drops++;
    tick();
    bus.response_in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    areset = 1'b1;
    q0.delete();
    q1.delete();
    exp_drops = 0;
    repeat (cycles) tick();
    areset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(bus.response_out_valid), 64'd0);
    check({tag, "_prog_full"}, 64'(bus.fifo_response_prog_full_out), 64'd0);
    check({tag, "_setup"}, 64'(bus.fifo_setup_signal), 64'd1);
    check({tag, "_drop_count"}, 64'(bus.drop_count_out), 64'd0);
  endtask

  task automatic wait_setup(input string tag, input bit check_len);
    int n = 0;
    while (bus.fifo_setup_signal && n < 20) begin
      n++;
      tick();
    end
    if (check_len) check({tag, "_setup_cycles"}, 64'(n), 64'd4);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(q0.size() + q1.size()), 64'd0);
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lat, c;
    areset = 1'b1;
    bus.response_in_valid      = 1'b0;
    bus.response_in_payload    = '0;
    bus.fifo_response_rd_en_in = '1;

    do_reset(3);
    check_reset_values("por");
    wait_setup("por", 1'b1);

    // Single packet to engine 1: exact 7-cycle latency.
    push(64'h0000_0000_0000_0001);
    lat = 1;
    while (bus.response_out_valid == '0 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd7);
    check("latency_valid", 64'(bus.response_out_valid), 64'd2);
    drain("single", 20);

    // 20 back-to-back packets alternating engines.
    base = seen_valid;
    for (int k = 0; k < 20; k++)
      push({40'h0, 8'hA0, 8'(k), 4'h0, 4'(k % 2)});
    drain("alternate", 200);
    check("alternate_count", 64'(seen_valid - base), 64'd20);

    // Out-of-range destination is dropped.
    base = seen_valid;
    push(64'h0000_DEAD_BEEF_0003);
    repeat (20) tick();
    check("drop_no_output", 64'(seen_valid - base), 64'd0);
    check("drop_count", 64'(bus.drop_count_out), exp_drop_value());

    // Head-of-line blocking: engine 0 stalled, engine 1 packet stuck behind it.
    bus.fifo_response_rd_en_in = 2'b10;
    base = seen_valid;
    for (int k = 0; k < 16; k++)
      push({40'h0, 8'hB0, 8'(k), 8'h00});
    push(64'h0000_0000_0000_B101);
    repeat (60) tick();
    check("blocked_no_output", 64'(seen_valid - base), 64'd0);
    check("blocked_prog_full", 64'(bus.fifo_response_prog_full_out), 64'd0);
    bus.fifo_response_rd_en_in = '1;
    drain("blocked_release", 200);
    check("blocked_count", 64'(seen_valid - base), 64'd17);

    // Upstream pushes every cycle until prog_full; ingress reaches 12 at cycle 24.
    bus.fifo_response_rd_en_in = '0;
    base = seen_valid;
    c = 0;
    while (!bus.fifo_response_prog_full_out && c < 60) begin
      push({40'h0, 8'hC0, 8'(c), 8'h00});
      c++;
    end
    check("prog_full_rise_cycle", 64'(c), 64'd25);
    repeat (10) tick();
    check("prog_full_hold", 64'(bus.fifo_response_prog_full_out), 64'd1);
    bus.fifo_response_rd_en_in = '1;
    drain("prog_full_release", 300);
    check("prog_full_count", 64'(seen_valid - base), 64'd25);
    check("prog_full_clear", 64'(bus.fifo_response_prog_full_out), 64'd0);

    // Reset with 5 packets in flight: nothing stale may emerge.
    base = seen_valid;
    for (int k = 0; k < 5; k++)
      push({40'h0, 8'hD0, 8'(k), 4'h0, 4'(k % 2)});
    do_reset(1);
    check_reset_values("midrst");
    repeat (40) tick();
    check("midrst_no_stale", 64'(seen_valid - base), 64'd0);

    // Recovery after reset.
    wait_setup("recover", 1'b0);
    base = seen_valid;
    push(64'h0000_0000_0000_E000);
    drain("recover", 30);
    check("recover_count", 64'(seen_valid - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
